// File: rtl/reg_file_pkg.sv
// Shared constants for the scoreboarded register file.
package reg_file_pkg;
   localparam int DW_DEF    = 8;
   localparam int PW_DEF    = 3;
   localparam int NFLAG_DEF = 3;

   // condition flag bit positions
   localparam int FLG_ZERO  = 0;
   localparam int FLG_NGTV  = 1;
   localparam int FLG_SCRY  = 2;
endpackage

// File: rtl/reg_file_sb_flag_reg.sv
// Condition flag register with a per-bit update mask.
module flag_reg #(
   parameter int NFLAG = 3
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic [NFLAG-1:0] i_mask,
   input  logic [NFLAG-1:0] i_din,
   output logic [NFLAG-1:0] o_q
);
   logic [NFLAG-1:0] r_q;

   // masked bits take the new value, unmasked bits hold
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     r_q <= '0;
      else if (i_en) r_q <= (r_q & ~i_mask) | (i_din & i_mask);
   end

   assign o_q = r_q;
endmodule

// File: rtl/reg_file_sb.sv
// Register file with load-pending scoreboard, two write ports with read
// bypass, masked condition flags and a sticky protocol-error bit.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int PW      = PW_DEF,
   parameter int NFLAG   = NFLAG_DEF,
   parameter int ZERO_R0 = 0
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             wa_en,
   input  logic [PW-1:0]    wa_addr,
   input  logic [DW-1:0]    wa_data,
   input  logic             wb_en,
   input  logic [PW-1:0]    wb_addr,
   input  logic [DW-1:0]    wb_data,
   input  logic             rsv_en,
   input  logic [PW-1:0]    rsv_addr,
   input  logic [PW-1:0]    rd_addrA,
   input  logic [PW-1:0]    rd_addrB,
   output logic [DW-1:0]    datA_out,
   output logic [DW-1:0]    datB_out,
   output logic             busyA,
   output logic             busyB,
   input  logic             flg_en,
   input  logic [NFLAG-1:0] flg_mask,
   input  logic [NFLAG-1:0] flg_in,
   output logic [NFLAG-1:0] flags_out,
   output logic             err_out
);
   localparam int DEPTH = 2**PW;

   logic [DW-1:0]    r_mem [DEPTH];
   logic [DEPTH-1:0] r_pend;
   logic             r_err;

   logic             w_wa, w_wb, w_rsv, w_err_set;
   logic [PW-1:0]    w_ra   [2];
   logic [DW-1:0]    w_dat  [2];
   logic             w_busy [2];

   // register 0 is hardwired to zero when ZERO_R0 is set
   function automatic logic is_r0(input logic [PW-1:0] a);
      return (ZERO_R0 != 0) && (a == '0);
   endfunction

   // accesses to a hardwired r0 are simply dropped
   assign w_wa  = wa_en  && !is_r0(wa_addr);
   assign w_wb  = wb_en  && !is_r0(wb_addr);
   assign w_rsv = rsv_en && !is_r0(rsv_addr);

   assign w_ra[0] = rd_addrA;
   assign w_ra[1] = rd_addrB;

   // read mux: wa bypass beats wb bypass beats stored value; any same-cycle write releases busy
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_dat[p]  = r_mem[w_ra[p]];
         w_busy[p] = r_pend[w_ra[p]];
         if (w_wb && wb_addr == w_ra[p]) begin
            w_dat[p]  = wb_data;
            w_busy[p] = 1'b0;
         end
         if (w_wa && wa_addr == w_ra[p]) begin
            w_dat[p]  = wa_data;
            w_busy[p] = 1'b0;
         end
         if (is_r0(w_ra[p])) begin
            w_dat[p]  = '0;
            w_busy[p] = 1'b0;
         end
      end
   end

   assign datA_out = w_dat[0];
   assign datB_out = w_dat[1];
   assign busyA    = w_busy[0];
   assign busyB    = w_busy[1];

   // protocol violations: unexpected return, double reservation, ALU write over an outstanding load
   assign w_err_set = (w_wb  && !r_pend[wb_addr])
                   || (w_rsv &&  r_pend[rsv_addr])
                   || (w_wa  &&  r_pend[wa_addr] && !(w_wb && wb_addr == wa_addr));

   // register array: wa is written last so the younger result wins a collision
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_wb) r_mem[wb_addr] <= wb_data;
         if (w_wa) r_mem[wa_addr] <= wa_data;
      end
   end

   // pending bits: a new reservation overrides a same-cycle return
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend <= '0;
      end else begin
         if (w_wb)  r_pend[wb_addr]  <= 1'b0;
         if (w_rsv) r_pend[rsv_addr] <= 1'b1;
      end
   end

   // sticky error, cleared only by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
   end

   assign err_out = r_err;

   flag_reg #(.NFLAG(NFLAG)) u_flags (
      .clk    (clk),
      .reset  (reset),
      .i_en   (flg_en),
      .i_mask (flg_mask),
      .i_din  (flg_in),
      .o_q    (flags_out)
   );
endmodule
